// File: rtl/accum_pkg.sv
// Shared definitions for the frame accumulator: parameter defaults and FSM encoding.
package accum_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : accum_pkg

// File: rtl/accum_unit_ripple_adder.sv
// 32-bit ripple-carry adder built from a chain of full-adder cells.
module RippleAdder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[32];

endmodule : RippleAdder

// File: rtl/accum_unit.sv
// Frame accumulator: sums frame_len operands through a ripple adder, tracks
// any carry-out as a sticky overflow flag, and presents the result with a
// valid/ready handshake.
module accum_unit
  import accum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             beat;

  // The adder sees the running total and the incoming operand every cycle;
  // its result is only captured on an accepted beat.
  RippleAdder u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign beat = in_valid && in_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (frame_len == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (beat && cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // Datapath next values: clear on frame start, accumulate on each beat,
  // hold otherwise (gaps, DONE stall, ignored start).
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && start) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = frame_len;
    end else if (beat) begin
      acc_d = add_sum;
      ovf_d = ovf_q | add_cout;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_sum = acc_q;
  assign out_ovf = ovf_q;

endmodule : accum_unit

// File: tb/tb_accum_unit.sv
// Directed self-checking bench for accum_unit.
module tb_accum_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  frame_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  accum_unit #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for exactly one edge.
  task automatic drive_start(input logic [7:0] len);
    start     = 1'b1;
    frame_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; frame_len = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_sum !== 32'd0) begin errors++; $display("FAIL reset_sum: got %0h expected 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", out_ovf); end
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %0b expected 0", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    drive_start(8'd3);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %0b expected 1", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %0b expected 1", busy); end
    in_valid = 1'b1; in_data = 32'd1; tick();
    in_data = 32'd2; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %0b expected 0", out_valid); end
    in_data = 32'd3; tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b expected 1", out_valid); end
    checks++; if (out_sum !== 32'd6) begin errors++; $display("FAIL b2b_sum: got %0h expected 6", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %0b expected 0", out_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_in_ready: got %0b expected 0", in_ready); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_exit_busy: got %0b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_exit_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    drive_start(8'd2);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; tick();
    checks++; if (out_sum !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_partial_sum: got %0h expected ffffffff", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_partial_flag: got %0b expected 0", out_ovf); end
    in_data = 32'h0000_0002; tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %0b expected 1", out_valid); end
    checks++; if (out_sum !== 32'h0000_0001) begin errors++; $display("FAIL ovf_sum: got %0h expected 1", out_sum); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", out_ovf); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  // Runs right after the overflow frame so acc/ovf are nonzero beforehand.
  task automatic test_zero_len();
    drive_start(8'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %0b expected 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_sum !== 32'd0) begin errors++; $display("FAIL zero_sum: got %0h expected 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf: got %0b expected 0", out_ovf); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_exit_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_stall();
    logic [31:0] ops [4];
    logic [31:0] exp_sum;
    ops[0] = 32'd10; ops[1] = 32'd20; ops[2] = 32'd30; ops[3] = 32'd40;
    exp_sum = 32'd0;
    drive_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ops[i]; tick();
      exp_sum = exp_sum + ops[i];
      in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
      if (i < 3) begin
        tick();
        checks++; if (out_sum !== exp_sum) begin errors++; $display("FAIL stall_gap_sum[%0d]: got %0h expected %0h", i, out_sum, exp_sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_gap_ready[%0d]: got %0b expected 1", i, in_ready); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %0b expected 1", out_valid); end
    checks++; if (out_sum !== 32'd100) begin errors++; $display("FAIL stall_sum: got %0h expected 64", out_sum); end
    in_valid = 1'b1; in_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid[%0d]: got %0b expected 1", i, out_valid); end
      checks++; if (out_sum !== 32'd100) begin errors++; $display("FAIL stall_hold_sum[%0d]: got %0h expected 64", i, out_sum); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL stall_hold_ovf[%0d]: got %0b expected 0", i, out_ovf); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    drive_start(8'd4);
    in_valid = 1'b1; in_data = 32'd7; tick();
    in_data = 32'd8; tick();
    in_valid = 1'b0;
    checks++; if (out_sum !== 32'd15) begin errors++; $display("FAIL rmid_partial: got %0h expected f", out_sum); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b expected 0", out_valid); end
    checks++; if (out_sum !== 32'd0) begin errors++; $display("FAIL rmid_sum: got %0h expected 0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rmid_ovf: got %0b expected 0", out_ovf); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive_start(8'd2);
    in_valid = 1'b1; in_data = 32'd5; tick();
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_new_valid: got %0b expected 1", out_valid); end
    checks++; if (out_sum !== 32'd10) begin errors++; $display("FAIL rmid_new_sum: got %0h expected a", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rmid_new_ovf: got %0b expected 0", out_ovf); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    drive_start(8'd3);
    start = 1'b1; frame_len = 8'd1; tick(); start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ign_accum_ready: got %0b expected 1", in_ready); end
    checks++; if (out_sum !== 32'd0) begin errors++; $display("FAIL ign_accum_sum: got %0h expected 0", out_sum); end
    in_valid = 1'b1; in_data = 32'd100; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ign_beat1_valid: got %0b expected 0", out_valid); end
    start = 1'b1; frame_len = 8'd0; in_data = 32'd200; tick(); start = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ign_beat2_valid: got %0b expected 0", out_valid); end
    checks++; if (out_sum !== 32'd300) begin errors++; $display("FAIL ign_beat2_sum: got %0h expected 12c", out_sum); end
    in_data = 32'd300; tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ign_done_valid: got %0b expected 1", out_valid); end
    checks++; if (out_sum !== 32'd600) begin errors++; $display("FAIL ign_done_sum: got %0h expected 258", out_sum); end
    out_ready = 1'b1; start = 1'b1; frame_len = 8'd2; tick();
    out_ready = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_exit_busy: got %0b expected 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_exit_ready: got %0b expected 0", in_ready); end
    checks++; if (out_sum !== 32'd600) begin errors++; $display("FAIL ign_exit_sum: got %0h expected 258", out_sum); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle_busy: got %0b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overflow();
    test_zero_len();
    test_stall();
    test_reset_mid_frame();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_accum_unit
